// File: rtl/dmem_ctrl.sv
// Data-memory controller: single-outstanding load/store front end for an
// internal synchronous RAM, with a programmable number of wait states.
module dmem_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] data_out,
  output logic              rvalid,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  // Guarded so a zero-wait build does not underflow the counter preload.
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ready_q;
  logic [DATA_W-1:0] data_out_q;
  logic              rvalid_q;
  logic              done_q;

  logic [DATA_W-1:0] mem_q [0:(1 << ADDR_W) - 1];
  logic              mem_we_d;

  // A reset landing on the ACCESS edge must drop the pending store.
  assign mem_we_d = (state_q == S_ACCESS) && wr_q && !rst;

  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      ready_q    <= 1'b1;
      data_out_q <= '0;
      rvalid_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            addr_q  <= addr;
            wr_q    <= wr;
            wdata_q <= wdata;
            ready_q <= 1'b0;
            cnt_q   <= CNT_INIT;
            state_q <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_ACCESS;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ACCESS: begin
          if (!wr_q) begin
            data_out_q <= mem_q[addr_q];
            rvalid_q   <= 1'b1;
          end
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready    = ready_q;
  assign data_out = data_out_q;
  assign rvalid   = rvalid_q;
  assign done     = done_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: table-driven load/store vectors on a one-wait build,
// plus corner sequences and latency checks on zero- and three-wait builds.
module tb_dmem_ctrl;

  logic clk;
  logic rst;

  logic        req1, wr1, ready1, rvalid1, done1;
  logic [7:0]  addr1;
  logic [15:0] wdata1, data_out1;
  logic        req0, wr0, ready0, rvalid0, done0;
  logic [7:0]  addr0;
  logic [15:0] wdata0, data_out0;
  logic        req3, wr3, ready3, rvalid3, done3;
  logic [7:0]  addr3;
  logic [15:0] wdata3, data_out3;

  int checks = 0;
  int errors = 0;
  int done_cnt1 = 0;
  logic [15:0] exp_q [$];
  logic [15:0] dout_model = 16'h0000;

  typedef struct {
    logic        w;
    logic [7:0]  a;
    logic [15:0] d;
    logic [15:0] e;
  } vec_t;
  vec_t tbl [13];

  dmem_ctrl #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .wr(wr1), .addr(addr1), .wdata(wdata1),
    .ready(ready1), .data_out(data_out1), .rvalid(rvalid1), .done(done1)
  );
  dmem_ctrl #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .wr(wr0), .addr(addr0), .wdata(wdata0),
    .ready(ready0), .data_out(data_out0), .rvalid(rvalid0), .done(done0)
  );
  dmem_ctrl #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .wr(wr3), .addr(addr3), .wdata(wdata3),
    .ready(ready3), .data_out(data_out3), .rvalid(rvalid3), .done(done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every rvalid pulse of the one-wait build pops one expected load.
  always @(negedge clk) begin
    if (rvalid1 === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: rvalid with data 0x%0h, expected no load", data_out1);
      end else begin
        chk("sb_load_data", data_out1, exp_q.pop_front());
      end
    end
    if (done1 === 1'b1) done_cnt1++;
  end

  // Called at a negedge with dut1 idle; returns at a negedge with dut1 idle.
  task automatic access1(input logic w, input logic [7:0] a, input logic [15:0] d,
                         input logic [15:0] e, input string tag);
    int k;
    chk($sformatf("%s_ready_before", tag), ready1, 1);
    req1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d;
    if (!w) exp_q.push_back(e);
    @(negedge clk);
    chk($sformatf("%s_ready_low", tag), ready1, 0);
    req1 = 1'b0; wr1 = ~w; addr1 = ~a; wdata1 = ~d;
    k = 0;
    while (done1 !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("%s_latency", tag), k, 2);
    chk($sformatf("%s_rvalid", tag), rvalid1, !w);
    chk($sformatf("%s_ready_at_done", tag), ready1, 1);
    if (!w) dout_model = e;
    chk($sformatf("%s_data_out", tag), data_out1, dout_model);
    @(negedge clk);
    chk($sformatf("%s_pulse_end", tag), {done1, rvalid1}, 0);
    chk($sformatf("%s_data_hold", tag), data_out1, dout_model);
    $display("txn %s: wr=%0b addr=0x%02h wdata=0x%04h latency=%0d data_out=0x%04h",
             tag, w, a, d, k, data_out1);
  endtask

  task automatic lat_pair(input logic w, input logic [7:0] a, input logic [15:0] d,
                          input logic [15:0] e, input string tag);
    int rv0 = -1, rv3 = -1, dn0 = -1, dn3 = -1, rl0 = 0, rl3 = 0;
    req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d;
    req3 = 1'b1; wr3 = w; addr3 = a; wdata3 = d;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        req0 = 1'b0; req3 = 1'b0;
      end
      if (ready0 !== 1'b1) rl0++;
      if (ready3 !== 1'b1) rl3++;
      if (done0 === 1'b1 && dn0 < 0) dn0 = k;
      if (done3 === 1'b1 && dn3 < 0) dn3 = k;
      if (rvalid0 === 1'b1 && rv0 < 0) rv0 = k;
      if (rvalid3 === 1'b1 && rv3 < 0) rv3 = k;
    end
    chk($sformatf("%s_w0_done_lat", tag), dn0, 1);
    chk($sformatf("%s_w3_done_lat", tag), dn3, 4);
    chk($sformatf("%s_w0_ready_low", tag), rl0, 1);
    chk($sformatf("%s_w3_ready_low", tag), rl3, 4);
    chk($sformatf("%s_w0_rvalid_lat", tag), rv0, w ? -1 : 1);
    chk($sformatf("%s_w3_rvalid_lat", tag), rv3, w ? -1 : 4);
    if (!w) begin
      chk($sformatf("%s_w0_data", tag), data_out0, e);
      chk($sformatf("%s_w3_data", tag), data_out3, e);
    end
    $display("txn %s: wr=%0b addr=0x%02h w0 done@%0d rvalid@%0d, w3 done@%0d rvalid@%0d",
             tag, w, a, dn0, rv0, dn3, rv3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    int rv_k [$];

    tbl[0]  = '{1'b1, 8'h12, 16'hBEEF, 16'h0000};
    tbl[1]  = '{1'b0, 8'h12, 16'h0000, 16'hBEEF};
    tbl[2]  = '{1'b1, 8'h01, 16'h1111, 16'h0000};
    tbl[3]  = '{1'b1, 8'h02, 16'h2222, 16'h0000};
    tbl[4]  = '{1'b1, 8'h55, 16'h5555, 16'h0000};
    tbl[5]  = '{1'b1, 8'h20, 16'h1234, 16'h0000};
    tbl[6]  = '{1'b1, 8'hFF, 16'hA5A5, 16'h0000};
    tbl[7]  = '{1'b1, 8'h00, 16'h5A5A, 16'h0000};
    tbl[8]  = '{1'b0, 8'hFF, 16'h0000, 16'hA5A5};
    tbl[9]  = '{1'b0, 8'h00, 16'h0000, 16'h5A5A};
    tbl[10] = '{1'b0, 8'h01, 16'h0000, 16'h1111};
    tbl[11] = '{1'b0, 8'h20, 16'h0000, 16'h1234};
    tbl[12] = '{1'b0, 8'h55, 16'h0000, 16'h5555};

    rst = 1'b1;
    req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    req0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
    req3 = 1'b0; wr3 = 1'b0; addr3 = '0; wdata3 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", ready1, 1);
    chk("rst_data_out", data_out1, 16'h0000);
    chk("rst_pulses", {rvalid1, done1}, 0);
    chk("rst_w0_ready", ready0, 1);
    chk("rst_w3_data_out", data_out3, 16'h0000);
    $display("txn reset: ready=%0b data_out=0x%04h rvalid=%0b done=%0b",
             ready1, data_out1, rvalid1, done1);

    for (int i = 0; i < 13; i++) begin
      access1(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].e, $sformatf("vec%0d", i));
    end

    // Back-to-back loads with req held high across the completion cycle.
    req1 = 1'b1; wr1 = 1'b0; addr1 = 8'h01; exp_q.push_back(16'h1111);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k == 0) begin
        addr1 = 8'h02; exp_q.push_back(16'h2222);
      end
      if (k == 2) chk("b2b_ready_return", ready1, 1);
      if (k == 3) begin
        chk("b2b_second_accept", ready1, 0);
        req1 = 1'b0;
      end
      if (rvalid1 === 1'b1) rv_k.push_back(k);
    end
    chk("b2b_rvalid_count", rv_k.size(), 2);
    if (rv_k.size() >= 2) begin
      chk("b2b_first_rvalid", rv_k[0], 2);
      chk("b2b_spacing", rv_k[1] - rv_k[0], 3);
    end
    dout_model = 16'h2222;
    chk("b2b_final_data", data_out1, 16'h2222);
    $display("txn b2b: rvalid pulses=%0d data_out=0x%04h", rv_k.size(), data_out1);

    // Requests while busy are ignored, not queued.
    dc = done_cnt1;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 8'h12; exp_q.push_back(16'hBEEF);
    @(negedge clk);
    req1 = 1'b1; wr1 = 1'b1; addr1 = 8'h55; wdata1 = 16'hDEAD;
    @(negedge clk);
    req1 = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_done_count", done_cnt1 - dc, 1);
    dout_model = 16'hBEEF;
    $display("txn busy: done pulses=%0d", done_cnt1 - dc);
    access1(1'b0, 8'h55, 16'h0000, 16'h5555, "busy_rd");

    // Reset during WAIT drops the pending store.
    dc = done_cnt1;
    req1 = 1'b1; wr1 = 1'b1; addr1 = 8'h20; wdata1 = 16'hAAAA;
    @(negedge clk);
    req1 = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw_ready", ready1, 1);
    chk("rstw_pulses", {done1, rvalid1}, 0);
    chk("rstw_data_out", data_out1, 16'h0000);
    dout_model = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rstw_no_done", done_cnt1 - dc, 0);
    $display("txn rst_wait: ready=%0b done pulses=%0d", ready1, done_cnt1 - dc);
    access1(1'b0, 8'h20, 16'h0000, 16'h1234, "rstw_rd");

    // Reset landing on the ACCESS edge also drops the store.
    dc = done_cnt1;
    req1 = 1'b1; wr1 = 1'b1; addr1 = 8'h20; wdata1 = 16'hBBBB;
    @(negedge clk);
    req1 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rsta_pulses", {done1, rvalid1}, 0);
    chk("rsta_data_out", data_out1, 16'h0000);
    dout_model = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rsta_no_done", done_cnt1 - dc, 0);
    $display("txn rst_access: ready=%0b done pulses=%0d", ready1, done_cnt1 - dc);
    access1(1'b0, 8'h20, 16'h0000, 16'h1234, "rsta_rd");

    lat_pair(1'b1, 8'h33, 16'h0C0C, 16'h0000, "lat_st33");
    lat_pair(1'b0, 8'h33, 16'h0000, 16'h0C0C, "lat_ld33");
    lat_pair(1'b1, 8'hFF, 16'h7E7E, 16'h0000, "lat_stFF");
    lat_pair(1'b0, 8'hFF, 16'h0000, 16'h7E7E, "lat_ldFF");

    chk("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
